ff_goodness_unit: RTL and testbench

Downstream consumer of the neuron core in the forward-forward (FF) datapath. After a sample's time steps finish, it sweeps the post-neuron SRAM one parallel group at a time and reduces the per-neuron spike counts or membrane potentials into a single layer goodness value. It compares that value against a programmable threshold and hands both results to the FF-STDP learning controller through a start/done handshake.

---
 rtl/ff_goodness_pkg.sv | 28 ++
 rtl/ff_goodness_if.sv | 37 +++
 rtl/ff_goodness_lane.sv | 23 ++
 rtl/ff_goodness_unit.sv | 133 +++++++++++++
 tb/tb_ff_goodness_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ff_goodness_pkg.sv
// Shared types and helpers for the forward-forward goodness reduction unit:
// FSM state encoding, MODE encodings and lane-term / saturation width helpers.
package ff_goodness_pkg;

  typedef enum logic [1:0] {
    GD_IDLE  = 2'd0,
    GD_SWEEP = 2'd1,
    GD_DRAIN = 2'd2,
    GD_DONE  = 2'd3
  } gd_state_t;

  typedef enum logic {
    GD_MODE_SCNT_SQ  = 1'b0,
    GD_MODE_RELU_MEM = 1'b1
  } gd_mode_t;

  localparam int GD_GOODNESS_WIDTH = 24;

  // A lane term must hold either a squared spike count or a non-negative membrane.
  function automatic int gd_term_width(input int mem_w, input int cnt_w);
    return (2 * cnt_w > mem_w) ? 2 * cnt_w : mem_w;
  endfunction

  function automatic logic [63:0] gd_sat_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/ff_goodness_if.sv
// Bus between the goodness unit, the post-neuron SRAM read port and the
// FF-STDP learning controller.
interface ff_goodness_if
  import ff_goodness_pkg::*;
#(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int GOODNESS_WIDTH            = GD_GOODNESS_WIDTH
);
  // start is a single-cycle request honoured only while busy is low; each
  // honoured start yields exactly one done pulse, and goodness/good_above_thr
  // are valid from that pulse until the next one.
  logic                                                    start;
  gd_mode_t                                                mode;
  logic [GOODNESS_WIDTH-1:0]                               goodness_thr;
  logic [POST_NEUR_SPIKE_CNT_WIDTH*POST_NEUR_PARALLEL-1:0] post_neur_s_cnt;
  logic [POST_NEUR_MEM_WIDTH*POST_NEUR_PARALLEL-1:0]       post_neur_mem_bus;
  logic                                                    gd_post_neur_cs;
  logic [POST_NEUR_ADDR_WIDTH-1:0]                         gd_post_neuron_address;
  logic                                                    busy;
  logic                                                    done;
  logic [GOODNESS_WIDTH-1:0]                               goodness;
  logic                                                    good_above_thr;

  modport master (
    output start, mode, goodness_thr, post_neur_s_cnt, post_neur_mem_bus,
    input  gd_post_neur_cs, gd_post_neuron_address, busy, done, goodness, good_above_thr
  );

  modport slave (
    input  start, mode, goodness_thr, post_neur_s_cnt, post_neur_mem_bus,
    output gd_post_neur_cs, gd_post_neuron_address, busy, done, goodness, good_above_thr
  );

endinterface

// File: rtl/ff_goodness_lane.sv
// One lane of the goodness reduction: squared spike count or ReLU of the
// signed membrane, selected by the latched mode.
module ff_goodness_lane
  import ff_goodness_pkg::*;
#(
  parameter int CNT_W  = 7,
  parameter int MEM_W  = 12,
  parameter int TERM_W = 14
) (
  input  gd_mode_t          i_mode,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [MEM_W-1:0]  i_mem,
  output logic [TERM_W-1:0] o_term
);

  logic [TERM_W-1:0] w_sq;
  logic [TERM_W-1:0] w_relu;

  assign w_sq   = TERM_W'(i_cnt) * TERM_W'(i_cnt);
  assign w_relu = i_mem[MEM_W-1] ? '0 : TERM_W'(i_mem);
  assign o_term = (i_mode == GD_MODE_RELU_MEM) ? w_relu : w_sq;

endmodule

// File: rtl/ff_goodness_unit.sv
// Sweeps the post-neuron SRAM one lane group per cycle and reduces it into a
// saturating layer goodness, then compares it against a latched threshold.
module ff_goodness_unit
  import ff_goodness_pkg::*;
#(
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int GOODNESS_WIDTH            = GD_GOODNESS_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ff_goodness_if.slave  bus,
  output gd_state_t     o_state
);

  localparam int G  = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int TW = gd_term_width(POST_NEUR_MEM_WIDTH, POST_NEUR_SPIKE_CNT_WIDTH);
  localparam int SW = TW + $clog2(POST_NEUR_PARALLEL);
  localparam int AW = ((GOODNESS_WIDTH > SW) ? GOODNESS_WIDTH : SW) + 1;
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] L_ADDR_STEP = POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] L_ADDR_LAST = POST_NEUR_ADDR_WIDTH'((G - 1) * POST_NEUR_PARALLEL);
  localparam logic [AW-1:0]                   L_SAT_MAX   = AW'(gd_sat_max(GOODNESS_WIDTH));

  gd_state_t                       r_state;
  gd_state_t                       w_state_next;
  gd_mode_t                        r_mode;
  logic [GOODNESS_WIDTH-1:0]       r_thr;
  logic [POST_NEUR_ADDR_WIDTH-1:0] r_addr;
  logic                            r_drain;
  logic                            r_rd_vld;
  logic                            r_s1_vld;
  logic [SW-1:0]                   r_grp_sum;
  logic [GOODNESS_WIDTH-1:0]       r_acc;
  logic [GOODNESS_WIDTH-1:0]       r_goodness;
  logic                            r_above;
  logic                            w_cs;
  logic [TW-1:0]                   w_term [POST_NEUR_PARALLEL];
  logic [SW-1:0]                   w_grp_sum;
  logic [AW-1:0]                   w_acc_sum;
  logic [GOODNESS_WIDTH-1:0]       w_acc_next;

  for (genvar l = 0; l < POST_NEUR_PARALLEL; l++) begin : g_lane
    ff_goodness_lane #(
      .CNT_W  (POST_NEUR_SPIKE_CNT_WIDTH),
      .MEM_W  (POST_NEUR_MEM_WIDTH),
      .TERM_W (TW)
    ) u_lane (
      .i_mode (r_mode),
      .i_cnt  (bus.post_neur_s_cnt[l*POST_NEUR_SPIKE_CNT_WIDTH +: POST_NEUR_SPIKE_CNT_WIDTH]),
      .i_mem  (bus.post_neur_mem_bus[l*POST_NEUR_MEM_WIDTH +: POST_NEUR_MEM_WIDTH]),
      .o_term (w_term[l])
    );
  end

  always_comb begin
    w_grp_sum = '0;
    for (int l = 0; l < POST_NEUR_PARALLEL; l++) begin
      w_grp_sum = w_grp_sum + SW'(w_term[l]);
    end
  end

  // Terms are never negative, so clamping each step equals clamping the total.
  assign w_acc_sum  = AW'(r_acc) + AW'(r_grp_sum);
  assign w_acc_next = !r_s1_vld ? r_acc :
                      (w_acc_sum > L_SAT_MAX) ? GOODNESS_WIDTH'(L_SAT_MAX) :
                      GOODNESS_WIDTH'(w_acc_sum);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= GD_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GD_IDLE:  if (bus.start) w_state_next = GD_SWEEP;
      GD_SWEEP: if (r_addr == L_ADDR_LAST) w_state_next = GD_DRAIN;
      GD_DRAIN: if (r_drain) w_state_next = GD_DONE;
      GD_DONE:  w_state_next = GD_IDLE;
      default:  w_state_next = GD_IDLE;
    endcase
  end

  always_comb begin
    w_cs                       = (r_state == GD_SWEEP);
    bus.gd_post_neur_cs        = w_cs;
    bus.gd_post_neuron_address = w_cs ? r_addr : '0;
    bus.busy                   = (r_state != GD_IDLE);
    bus.done                   = (r_state == GD_DONE);
    bus.goodness               = r_goodness;
    bus.good_above_thr         = r_above;
    o_state                    = r_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= GD_MODE_SCNT_SQ;
      r_thr      <= '0;
      r_addr     <= '0;
      r_drain    <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_grp_sum  <= '0;
      r_acc      <= '0;
      r_goodness <= '0;
      r_above    <= 1'b0;
    end else begin
      r_rd_vld  <= w_cs;
      r_s1_vld  <= r_rd_vld;
      r_grp_sum <= w_grp_sum;
      if (r_state == GD_IDLE && bus.start) begin
        r_mode  <= bus.mode;
        r_thr   <= bus.goodness_thr;
        r_addr  <= '0;
        r_drain <= 1'b0;
        r_acc   <= '0;
      end else begin
        r_acc <= w_acc_next;
      end
      if (r_state == GD_SWEEP) r_addr <= r_addr + L_ADDR_STEP;
      if (r_state == GD_DRAIN) r_drain <= ~r_drain;
      // The last group lands in the final drain cycle, so results use the next value.
      if (r_state == GD_DRAIN && r_drain) begin
        r_goodness <= w_acc_next;
        r_above    <= (w_acc_next > r_thr);
      end
    end
  end

endmodule

// File: tb/tb_ff_goodness_unit.sv
// Bench for ff_goodness_unit: two instances (24-bit and 16-bit goodness) share
// stimulus; a per-cycle checker compares them against a timing/sum model.
module tb_ff_goodness_unit;
  import ff_goodness_pkg::*;

  localparam int N   = 256;
  localparam int P   = 4;
  localparam int ADW = 10;
  localparam int MW  = 12;
  localparam int CW  = 7;
  localparam int GW  = 24;
  localparam int GWS = 16;
  localparam int G   = N / P;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ff_goodness_if #(.POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(ADW), .POST_NEUR_MEM_WIDTH(MW),
                   .POST_NEUR_SPIKE_CNT_WIDTH(CW), .GOODNESS_WIDTH(GW))  a_if ();
  ff_goodness_if #(.POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(ADW), .POST_NEUR_MEM_WIDTH(MW),
                   .POST_NEUR_SPIKE_CNT_WIDTH(CW), .GOODNESS_WIDTH(GWS)) b_if ();
  gd_state_t a_state, b_state;

  ff_goodness_unit #(.OUTPUT_NEURON(N), .POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(ADW),
                     .POST_NEUR_MEM_WIDTH(MW), .POST_NEUR_SPIKE_CNT_WIDTH(CW), .GOODNESS_WIDTH(GW))
    u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave), .o_state(a_state));
  ff_goodness_unit #(.OUTPUT_NEURON(N), .POST_NEUR_PARALLEL(P), .POST_NEUR_ADDR_WIDTH(ADW),
                     .POST_NEUR_MEM_WIDTH(MW), .POST_NEUR_SPIKE_CNT_WIDTH(CW), .GOODNESS_WIDTH(GWS))
    u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b_if.slave), .o_state(b_state));

  // ---------------- post-neuron SRAM model (synchronous read) ----------------
  int unsigned       cnt_arr [N];
  logic [MW-1:0]     mem_arr [N];
  logic [ADW-1:0]    a_raddr = '0;
  logic [ADW-1:0]    b_raddr = '0;

  always @(posedge clk) begin
    if (a_if.gd_post_neur_cs) a_raddr <= a_if.gd_post_neuron_address;
    if (b_if.gd_post_neur_cs) b_raddr <= b_if.gd_post_neuron_address;
  end

  always_comb begin
    a_if.post_neur_s_cnt   = '0;
    a_if.post_neur_mem_bus = '0;
    b_if.post_neur_s_cnt   = '0;
    b_if.post_neur_mem_bus = '0;
    for (int l = 0; l < P; l++) begin
      a_if.post_neur_s_cnt[l*CW +: CW]   = CW'(cnt_arr[(int'(a_raddr) + l) % N]);
      a_if.post_neur_mem_bus[l*MW +: MW] = mem_arr[(int'(a_raddr) + l) % N];
      b_if.post_neur_s_cnt[l*CW +: CW]   = CW'(cnt_arr[(int'(b_raddr) + l) % N]);
      b_if.post_neur_mem_bus[l*MW +: MW] = mem_arr[(int'(b_raddr) + l) % N];
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [GW-1:0]  exp_q   [$];
  logic [GWS-1:0] exp16_q [$];
  logic [1:0]     abv_q   [$];
  logic [GW-1:0]  hold_a   = '0;
  logic [GWS-1:0] hold_b   = '0;
  logic [1:0]     hold_abv = '0;
  logic           active   = 1'b0;
  int             t0       = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-layer sum straight from the neuron arrays, clamped to the result width.
  function automatic longint model_goodness(input gd_mode_t md, input int w);
    longint s  = 0;
    longint mx = (longint'(1) << w) - 1;
    for (int n = 0; n < N; n++) begin
      if (md == GD_MODE_SCNT_SQ) s += longint'(cnt_arr[n]) * longint'(cnt_arr[n]);
      else if (!mem_arr[n][MW-1]) s += longint'(mem_arr[n]);
    end
    return (s > mx) ? mx : s;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int d;
    logic e_cs, e_busy, e_done;
    logic [ADW-1:0] e_addr;
    d      = cyc - t0;
    e_cs   = active && d >= 1 && d <= G;
    e_busy = active && d >= 1 && d <= G + 3;
    e_done = active && d == G + 3;
    e_addr = e_cs ? ADW'((d - 1) * P) : '0;
    if (e_done) begin
      if (exp_q.size() == 0 || exp16_q.size() == 0 || abv_q.size() == 0) begin
        chk("exp_q_underflow", 0, 1);
      end else begin
        hold_a   = exp_q.pop_front();
        hold_b   = exp16_q.pop_front();
        hold_abv = abv_q.pop_front();
      end
    end
    chk("a_cs",   a_if.gd_post_neur_cs,        e_cs);
    chk("a_addr", a_if.gd_post_neuron_address, e_addr);
    chk("a_busy", a_if.busy,                   e_busy);
    chk("a_done", a_if.done,                   e_done);
    chk("a_idle", a_state == GD_IDLE,          !e_busy);
    chk("a_good", a_if.goodness,               hold_a);
    chk("a_abv",  a_if.good_above_thr,         hold_abv[1]);
    chk("b_cs",   b_if.gd_post_neur_cs,        e_cs);
    chk("b_busy", b_if.busy,                   e_busy);
    chk("b_done", b_if.done,                   e_done);
    chk("b_idle", b_state == GD_IDLE,          !e_busy);
    chk("b_good", b_if.goodness,               hold_b);
    chk("b_abv",  b_if.good_above_thr,         hold_abv[0]);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inputs(input gd_mode_t md, input logic [GW-1:0] thr);
    a_if.mode = md;
    b_if.mode = md;
    a_if.goodness_thr = thr;
    b_if.goodness_thr = thr[GWS-1:0];
  endtask

  // Drives START for the current cycle; the model accepts it only when idle.
  task automatic pulse_start(input gd_mode_t md, input logic [GW-1:0] thr);
    longint ga, gb;
    set_inputs(md, thr);
    a_if.start = 1'b1;
    b_if.start = 1'b1;
    if (rst_n && (!active || cyc >= t0 + G + 4)) begin
      ga = model_goodness(md, GW);
      gb = model_goodness(md, GWS);
      exp_q.push_back(GW'(ga));
      exp16_q.push_back(GWS'(gb));
      abv_q.push_back({ga > longint'(thr), gb > longint'(thr[GWS-1:0])});
      active = 1'b1;
      t0     = cyc;
    end
    next_cycle();
    a_if.start = 1'b0;
    b_if.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic run_sweep(input gd_mode_t md, input logic [GW-1:0] thr);
    next_cycle();
    pulse_start(md, thr);
    wait_until(t0 + G + 5);
  endtask

  task automatic fill(input int unsigned cnt, input logic [MW-1:0] mem);
    for (int n = 0; n < N; n++) begin
      cnt_arr[n] = cnt;
      mem_arr[n] = mem;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    set_inputs(GD_MODE_SCNT_SQ, '0);
    fill(0, '0);
    rst_n = 1'b0;
    repeat (3) next_cycle();
    chk("rst_good", a_if.goodness, 0);
    chk("rst_busy", a_if.busy, 0);
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // spike count 1 everywhere; STARTs mid-sweep and on the DONE cycle are ignored
    fill(1, '0);
    next_cycle();
    pulse_start(GD_MODE_SCNT_SQ, GW'(255));
    wait_until(t0 + 10);
    pulse_start(GD_MODE_RELU_MEM, GW'(0));
    wait_until(t0 + G + 3);
    pulse_start(GD_MODE_RELU_MEM, GW'(0));
    wait_until(t0 + G + 5);
    chk("lit_ones_good", a_if.goodness, 256);
    chk("lit_ones_abv255", a_if.good_above_thr, 1);

    run_sweep(GD_MODE_SCNT_SQ, GW'(256));
    chk("lit_ones_abv256", a_if.good_above_thr, 0);
    chk("lit_done_cycle", t0 + G + 3 - t0, 67);

    fill(127, 12'h800);
    run_sweep(GD_MODE_SCNT_SQ, GW'(0));
    chk("lit_cnt127", a_if.goodness, 4129024);
    chk("lit_cnt127_sat16", b_if.goodness, 65535);

    run_sweep(GD_MODE_RELU_MEM, GW'(0));
    chk("lit_mem_neg", a_if.goodness, 0);
    chk("lit_mem_neg_abv", a_if.good_above_thr, 0);

    fill(0, 12'h7FF);
    run_sweep(GD_MODE_RELU_MEM, GW'(100));
    chk("lit_mem_max", a_if.goodness, 524032);
    chk("lit_mem_max_sat16", b_if.goodness, 65535);

    // mixed values; MODE/THR wiggled mid-sweep must not matter
    for (int n = 0; n < N; n++) begin
      cnt_arr[n] = (n * 13) % 128;
      mem_arr[n] = MW'(n * 37 + 100);
    end
    for (int m = 0; m < 2; m++) begin
      next_cycle();
      pulse_start(gd_mode_t'(m), GW'(300000));
      wait_until(t0 + 5);
      set_inputs(gd_mode_t'(1 - m), GW'(0));
      wait_until(t0 + G + 5);
    end

    // reset mid-sweep, then a clean sweep with no stale accumulation
    fill(1, '0);
    next_cycle();
    pulse_start(GD_MODE_SCNT_SQ, GW'(100));
    wait_until(t0 + 30);
    rst_n  = 1'b0;
    active = 1'b0;
    exp_q.delete();
    exp16_q.delete();
    abv_q.delete();
    hold_a   = '0;
    hold_b   = '0;
    hold_abv = '0;
    #1;
    chk("rst_mid_cs", a_if.gd_post_neur_cs, 0);
    chk("rst_mid_busy", a_if.busy, 0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    run_sweep(GD_MODE_SCNT_SQ, GW'(100));
    chk("lit_after_rst", a_if.goodness, 256);
    chk("lit_after_rst_abv", a_if.good_above_thr, 1);

    repeat (3) next_cycle();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
